// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared constants for the windowed sequence detector
package seq_pkg;

    localparam int DEF_PAT_W = 4;
    localparam int DEF_CNT_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/seq_match_core.sv
// rtl/seq_match_core.sv - shift history, fill tracking and Mealy pattern compare
module seq_match_core
    import seq_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             signal,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic             match
);

    localparam int FW = $clog2(PAT_W);
    localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W - 1);

    logic [PAT_W-2:0] hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [PAT_W-1:0] window;

    always_comb begin
        window = {hist_q, signal};
        match  = shift_en && (fill_q == FILL_MAX) && (window == pattern);
    end

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clr) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift_en) begin
            hist_d = window[PAT_W-2:0];
            // A non-overlapping hit restarts the fill so the next match needs fresh bits
            if (match && !overlap) begin
                fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + FW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - windowed controller around the Mealy sequence matcher
module seq_detect_ctrl
    import seq_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    input  logic [CNT_W-1:0] win_len,
    input  logic             signal,
    input  logic             signal_vld,
    output logic             busy,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt,
    output logic             done
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0] win_q, win_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic             ovl_q, ovl_d;
    logic             clr;
    logic             shift_en;
    logic             match;

    seq_match_core #(.PAT_W(PAT_W)) u_core (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .shift_en (shift_en),
        .signal   (signal),
        .pattern  (pat_q),
        .overlap  (ovl_q),
        .match    (match)
    );

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        match_cnt_d = match_cnt_q;
        win_d       = win_q;
        pat_d       = pat_q;
        ovl_d       = ovl_q;
        clr         = 1'b0;
        shift_en    = (state_q == ST_RUN) && signal_vld;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pat_d       = pattern;
                    ovl_d       = overlap;
                    win_d       = win_len;
                    match_cnt_d = '0;
                    bit_cnt_d   = '0;
                    clr         = 1'b1;
                    state_d     = (win_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (signal_vld) begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (match && (match_cnt_q != '1)) begin
                        match_cnt_d = match_cnt_q + CNT_W'(1);
                    end
                    // win_q is never zero here, so the subtraction cannot wrap
                    if (bit_cnt_q == win_q - CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            match_cnt_q <= '0;
            win_q       <= '0;
            pat_q       <= '0;
            ovl_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            match_cnt_q <= match_cnt_d;
            win_q       <= win_d;
            pat_q       <= pat_d;
            ovl_q       <= ovl_d;
        end
    end

    always_comb begin
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE);
        out       = match;
        match_cnt = match_cnt_q;
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb/tb_seq_detect_ctrl.sv - scoreboard bench for seq_detect_ctrl
module tb_seq_detect_ctrl;

    localparam int PAT_W = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic             overlap;
    logic [CNT_W-1:0] win_len;
    logic             signal;
    logic             signal_vld;
    logic             busy;
    logic             out;
    logic [CNT_W-1:0] match_cnt;
    logic             done;

    int errors = 0;
    int checks = 0;

    logic stim_bits[$];
    logic exp_q[$];
    int   exp_total;

    seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pattern    (pattern),
        .overlap    (overlap),
        .win_len    (win_len),
        .signal     (signal),
        .signal_vld (signal_vld),
        .busy       (busy),
        .out        (out),
        .match_cnt  (match_cnt),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Reference: a match needs PAT_W bits since the last restart point, which a
    // non-overlapping hit moves to just past itself.
    function automatic void build_expect(input logic [PAT_W-1:0] pat, input logic ovl);
        int first = 0;
        logic [PAT_W-1:0] w;
        logic m;
        exp_q.delete();
        exp_total = 0;
        for (int i = 0; i < stim_bits.size(); i++) begin
            m = 1'b0;
            if (i - first >= PAT_W - 1) begin
                for (int j = 0; j < PAT_W; j++) w[PAT_W-1-j] = stim_bits[i-PAT_W+1+j];
                m = (w == pat);
            end
            if (m) begin
                exp_total++;
                if (!ovl) first = i + 1;
            end
            exp_q.push_back(m);
        end
    endfunction

    function automatic void load_1001x10();
        stim_bits = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    endfunction

    // Runs one full window over stim_bits; inj_idx >= 0 pulses a conflicting start on that bit
    task automatic run_stream(input string name, input logic [PAT_W-1:0] pat, input logic ovl,
                              input int gaps, input int inj_idx);
        logic e;
        build_expect(pat, ovl);
        @(negedge clk);
        start = 1'b1; pattern = pat; overlap = ovl; win_len = CNT_W'(stim_bits.size());
        signal_vld = 1'b0;
        for (int i = 0; i < stim_bits.size(); i++) begin
            for (int g = 0; g < gaps; g++) begin
                @(negedge clk);
                start = 1'b0; signal_vld = 1'b0; signal = 1'($urandom);
                #1;
                checks++;
                if (out !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL %s gap bit%0d: out=%b busy=%b done=%b required out=0 busy=1 done=0",
                             name, i, out, busy, done);
                end
            end
            @(negedge clk);
            start = (i == inj_idx);
            if (i == inj_idx) begin
                pattern = ~pat; overlap = ~ovl; win_len = 8'd3;
            end
            signal_vld = 1'b1; signal = stim_bits[i];
            #1;
            e = exp_q.pop_front();
            checks++;
            if (out !== e || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s bit%0d: out=%b busy=%b done=%b required out=%b busy=1 done=0",
                         name, i + 1, out, busy, done, e);
            end
        end
        @(negedge clk);
        start = 1'b0; signal_vld = 1'b0;
        #1;
        checks++;
        if (done !== 1'b1 || match_cnt !== CNT_W'(exp_total) || out !== 1'b0) begin
            errors++;
            $display("FAIL %s done: done=%b match_cnt=%0d out=%b required done=1 match_cnt=%0d out=0",
                     name, done, match_cnt, out, exp_total);
        end
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || match_cnt !== CNT_W'(exp_total)) begin
            errors++;
            $display("FAIL %s idle: busy=%b done=%b match_cnt=%0d required busy=0 done=0 match_cnt=%0d",
                     name, busy, done, match_cnt, exp_total);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; pattern = '0; overlap = 1'b0; win_len = '0;
        signal = 1'b1; signal_vld = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || match_cnt !== '0 || out !== 1'b0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b match_cnt=%0d out=%b required all 0",
                     busy, done, match_cnt, out);
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || out !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignores_signal: busy=%b out=%b required 0 0", busy, out);
        end
        signal_vld = 1'b0;
    endtask

    task automatic test_non_overlap();
        load_1001x10();
        run_stream("non_overlap", 4'b1001, 1'b0, 0, -1);
        checks++;
        if (exp_total != 2) begin
            errors++;
            $display("FAIL non_overlap_model: count=%0d required 2", exp_total);
        end
    endtask

    task automatic test_overlap();
        load_1001x10();
        run_stream("overlap", 4'b1001, 1'b1, 0, -1);
        checks++;
        if (match_cnt !== 8'd3) begin
            errors++;
            $display("FAIL overlap_cnt: match_cnt=%0d required 3", match_cnt);
        end
    endtask

    task automatic test_bit_order();
        stim_bits = '{1'b1, 1'b0, 1'b1, 1'b1};
        run_stream("bit_order_hit", 4'b1011, 1'b0, 0, -1);
        checks++;
        if (match_cnt !== 8'd1) begin
            errors++;
            $display("FAIL bit_order_hit_cnt: match_cnt=%0d required 1", match_cnt);
        end
        stim_bits = '{1'b1, 1'b1, 1'b0, 1'b1};
        run_stream("bit_order_miss", 4'b1011, 1'b0, 0, -1);
        checks++;
        if (match_cnt !== 8'd0) begin
            errors++;
            $display("FAIL bit_order_miss_cnt: match_cnt=%0d required 0", match_cnt);
        end
    endtask

    task automatic test_valid_gaps();
        load_1001x10();
        run_stream("valid_gaps", 4'b1001, 1'b0, 3, -1);
        checks++;
        if (match_cnt !== 8'd2) begin
            errors++;
            $display("FAIL valid_gaps_cnt: match_cnt=%0d required 2", match_cnt);
        end
    endtask

    task automatic test_zero_window_and_ignored_start();
        @(negedge clk);
        start = 1'b1; pattern = 4'b1001; overlap = 1'b0; win_len = '0;
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || match_cnt !== '0) begin
            errors++;
            $display("FAIL zero_win_done: done=%b busy=%b match_cnt=%0d required 1 1 0",
                     done, busy, match_cnt);
        end
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL zero_win_idle: busy=%b done=%b required 0 0", busy, done);
        end
        load_1001x10();
        run_stream("ignored_start", 4'b1001, 1'b0, 0, 4);
        checks++;
        if (match_cnt !== 8'd2) begin
            errors++;
            $display("FAIL ignored_start_cnt: match_cnt=%0d required 2", match_cnt);
        end
    endtask

    task automatic test_reset_mid_window();
        load_1001x10();
        @(negedge clk);
        start = 1'b1; pattern = 4'b1001; overlap = 1'b0; win_len = 8'd10;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = 1'b0; signal_vld = 1'b1; signal = stim_bits[i];
        end
        @(negedge clk);
        signal_vld = 1'b0;
        #1;
        checks++;
        if (match_cnt !== 8'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: match_cnt=%0d busy=%b required 1 1", match_cnt, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || match_cnt !== '0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b match_cnt=%0d done=%b required 0 0 0",
                     busy, match_cnt, done);
        end
        @(negedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_no_done: done=%b busy=%b required 0 0", done, busy);
        end
        run_stream("after_reset", 4'b1001, 1'b0, 0, -1);
    endtask

    task automatic test_back_to_back();
        stim_bits = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        run_stream("b2b_first", 4'b0110, 1'b1, 0, -1);
        stim_bits = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        run_stream("b2b_second", 4'b1111, 1'b0, 0, -1);
        for (int n = 0; n < 3; n++) begin
            stim_bits.delete();
            for (int i = 0; i < 20; i++) stim_bits.push_back(1'($urandom_range(0, 1)));
            run_stream("random", 4'($urandom), 1'(n), n, -1);
        end
    endtask

    initial begin
        test_reset();
        test_non_overlap();
        test_overlap();
        test_bit_order();
        test_valid_gaps();
        test_zero_window_and_ignored_start();
        test_reset_mid_window();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Windowed controller for serial pattern detection, built on the team's Mealy sequence-detector datapath. It is armed by a one-cycle start strobe carrying a programmable pattern, an overlap/non-overlap mode and a window length. It then scans exactly that many valid serial bits, pulses a Mealy match output on each detection and counts the detections. At the end of the window it reports done. It sits between the stimulus/config logic and the serial detectors, replacing per-pattern hard-wired FSMs such as the 1001 detector.

## Interface
Parameters:
- PAT_W, 4, pattern length in bits (≥2)
- CNT_W, 8, width of window length and match counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  arm request; sampled only in IDLE
- pattern  in  PAT_W  target pattern; pattern[PAT_W-1] is the first bit received
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping
- win_len  in  CNT_W  number of valid bits to scan
- signal  in  1  serial data bit
- signal_vld  in  1  signal is consumed this cycle
- busy  out  1  high in RUN and DONE
- out  out  1  Mealy match pulse (combinational)
- match_cnt  out  CNT_W  detections in current/last window
- done  out  1  one-cycle end-of-window pulse

## Operation
- **Reset values.** Reset forces state IDLE, busy=0, done=0, match_cnt=0, and clears history and fill. out is 0 whenever the block is not in RUN.
- **IDLE.** On start=1, latch pattern, overlap and win_len, clear match_cnt, bit_cnt, history and fill.
  - If win_len==0, go to DONE.
  - Otherwise go to RUN.
  - signal/signal_vld are ignored in IDLE.
- **RUN.** A bit is consumed only when signal_vld=1; in cycles with signal_vld=0 nothing changes.
  - The window bits are formed as {hist[PAT_W-2:0], signal}.
  - out = signal_vld & (fill ≥ PAT_W-1) & (window bits == latched pattern).
- **On a consumed bit:**
  - Shift signal into hist and increment bit_cnt.
  - fill increments, saturating at PAT_W-1.
  - If out=1, increment match_cnt (saturating at all-ones).
  - If out=1 and overlap=0, reset fill to 0 so matches cannot share bits. History contents are don't-care after this.
  - If the consumed bit is bit number win_len (bit_cnt==win_len-1 before the increment), go to DONE. A match on that final bit still counts and still pulses out.
- **DONE.** done=1 for exactly one cycle, then IDLE.
- **Output holding.** match_cnt holds its value through DONE and IDLE until the next accepted start.
- **start while busy.** start in RUN or DONE is ignored; it is not queued.
- **rst mid-window.** Returns to IDLE with reset values next cycle. No done pulse is issued.
- **Arithmetic.** bit_cnt is CNT_W bits; win_len=2^CNT_W-1 is the maximum window. fill is $clog2(PAT_W) bits.

## Timing
- start sampled high at edge k → busy=1 from cycle k+1.
- The first bit that can be consumed is sampled at edge k+1.
- out is valid combinationally in the same cycle as the matching bit; it is zero-latency Mealy.
- match_cnt reflects a match one edge after its out pulse.
- Last bit consumed at edge m → done=1 during cycle m+1 → IDLE (busy=0) from cycle m+2.
  - The earliest accepted re-start is sampled at edge m+2.
- win_len==0: start at edge k → done=1 in cycle k+1 → IDLE at k+2, match_cnt=0.

## Structure
- **Shared package.** seq_pkg holds the state enum (IDLE, RUN, DONE) and the default PAT_W/CNT_W constants.
- **Sub-module.** seq_match_core contains the shift history, fill counter, compare and overlap clear. It outputs the match signal.
  - Inputs: clk, rst, clr, shift_en, signal, pattern, overlap.
- **Top level.** seq_detect_ctrl holds the FSM, bit counter, match counter and config latches.

## Test plan
1. **Non-overlapping.** pattern=1001, overlap=0, win_len=10, all valid, stream 1,0,0,1,0,0,1,0,0,1 → out pulses on bits 4 and 10; match_cnt=2; done one cycle after bit 10.
2. **Overlapping.** Same stream with overlap=1 → out pulses on bits 4, 7 and 10; match_cnt=3.
3. **Bit order.** pattern=1011, win_len=4, stream 1,0,1,1 → match_cnt=1. Same pattern with stream 1,1,0,1 → match_cnt=0, no out pulse.
4. **Valid gaps.** pattern=1001 with signal_vld low for 3 cycles between each bit (signal toggling during gaps) → same result as scenario 1. busy stays high throughout; done arrives only after the 10th valid bit.
5. **Zero window and ignored start.** win_len=0 → done=1 in cycle k+1, match_cnt=0. Then start pulsed mid-RUN with a different pattern → ignored; the window completes with the original config.
6. **Reset mid-window.** rst=1 after 6 bits of scenario 1 → next cycle busy=0, match_cnt=0, no done. A new start then behaves exactly as scenario 1.
